serial_strobe_tx: RTL and testbench

Parallel-in, serial-out transmitter that drives a data line plus a level strobe for a gated D-latch receiver. The receiver is transparent while the strobe is high and captures on its falling edge. The block accepts one WIDTH-bit word per valid/ready handshake and shifts it out MSB first. Each bit gets a guaranteed setup phase, a strobe-high window and a hold cycle, so a NAND-built latch samples cleanly. It sits between a processor-side register and the latch-based storage/display datapath.

---
 rtl/serial_strobe_pkg.sv | 17 +
 rtl/serial_strobe_tx_if.sv | 33 +++
 rtl/serial_strobe_tx_phase_timer.sv | 40 ++++
 rtl/serial_strobe_tx.sv | 106 ++++++++++
 tb/tb_serial_strobe_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_strobe_pkg.sv
// rtl/serial_strobe_pkg.sv - shared types and helpers for serial_strobe_tx
//   state_e    : transmitter FSM state, 2-bit encoding
//   bit_period : cycles spent on one bit (setup + strobe-high + hold)
package serial_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic int bit_period(input int half_period);
        return 2 * half_period + 1;
    endfunction

endpackage

// File: rtl/serial_strobe_tx_if.sv
// rtl/serial_strobe_tx_if.sv - word handshake and serial latch bus for serial_strobe_tx
//   tx_data/tx_valid/tx_ready : producer-side word handshake
//   ser_d/ser_stb/ser_frame   : serial data, latch enable and frame marker
//   master : producer / observer side
//   slave  : transmitter side
interface serial_strobe_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             ser_d;
    logic             ser_stb;
    logic             ser_frame;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  ser_d,
        input  ser_stb,
        input  ser_frame
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output ser_d,
        output ser_stb,
        output ser_frame
    );
endinterface

// File: rtl/serial_strobe_tx_phase_timer.sv
// rtl/serial_strobe_tx_phase_timer.sv - loadable down-counter timing the SETUP and HIGH phases
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload to HALF_PERIOD-1 (takes priority over en)
//   en         : count down by one, stopping at zero
//   tc         : terminal count, high while the counter reads zero
module strobe_phase_timer #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/serial_strobe_tx.sv
// rtl/serial_strobe_tx.sv - parallel-in, MSB-first serial transmitter with level strobe for a gated D latch
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): tx_data/tx_valid/tx_ready word handshake,
//                ser_d/ser_stb/ser_frame serial latch outputs
module serial_strobe_tx
    import serial_strobe_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_strobe_tx_if.slave   bus
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              ser_d_q, ser_d_d;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_tc;

    strobe_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    // ser_d is only ever updated on the edge that enters SETUP, where the
    // strobe is low on both sides, so data never moves with a strobe edge.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ser_d_d   = ser_d_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    shift_d   = bus.tx_data;
                    bit_cnt_d = BIT_LAST;
                    ser_d_d   = bus.tx_data[WIDTH-1];
                    tmr_load  = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bit_cnt_q != '0) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    // Next bit is the one just below the current MSB.
                    ser_d_d   = shift_q[WIDTH-2];
                    tmr_load  = 1'b1;
                    state_d   = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ser_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ser_d_q   <= ser_d_d;
        end
    end

    assign bus.tx_ready  = (state_q == IDLE);
    assign bus.ser_stb   = (state_q == HIGH);
    assign bus.ser_frame = (state_q != IDLE);
    assign bus.ser_d     = ser_d_q;

endmodule

// File: tb/tb_serial_strobe_tx.sv
// tb/tb_serial_strobe_tx.sv - self-checking bench for serial_strobe_tx
module tb_serial_strobe_tx;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int P  = 5;
    localparam int NC = W * P;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_strobe_tx_if #(.WIDTH(W)) m_if ();
    serial_strobe_tx_if #(.WIDTH(2)) s_if ();

    serial_strobe_tx #(.WIDTH(W), .HALF_PERIOD(H)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    serial_strobe_tx #(.WIDTH(2), .HALF_PERIOD(1)) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gated D latch on the main DUT's serial outputs.
    logic       latch_q;
    logic [7:0] cap;
    int         cap_n;

    initial latch_q = 1'b0;
    always @(m_if.ser_stb or m_if.ser_d) begin
        if (m_if.ser_stb) latch_q = m_if.ser_d;
    end
    always @(negedge m_if.ser_stb) begin
        cap   = {cap[6:0], latch_q};
        cap_n = cap_n + 1;
    end

    task automatic start_word(input logic [7:0] word, input bit hold_valid);
        @(negedge clk);
        m_if.tx_data  = word;
        m_if.tx_valid = 1'b1;
        @(posedge clk);
        if (!hold_valid) begin
            #1;
            m_if.tx_valid = 1'b0;
        end
    endtask

    // Checks cycles 1..NC+1 after a handshake edge against the bit timing.
    task automatic check_frame(input logic [7:0] word, input bit scramble, input string name);
        int   k;
        int   ph;
        bit   in_frame;
        logic exp_stb;
        logic exp_d;
        cap   = '0;
        cap_n = 0;
        for (int c = 1; c <= NC + 1; c++) begin
            @(negedge clk);
            k        = (c - 1) / P;
            ph       = (c - 1) % P;
            in_frame = (c <= NC);
            exp_stb  = in_frame && (ph >= H) && (ph < 2 * H);
            exp_d    = in_frame ? word[7 - k] : word[0];
            n_checks += 4;
            if (m_if.ser_stb !== exp_stb) begin
                n_fail++;
                $display("FAIL %s stb cycle %0d: got %b want %b", name, c, m_if.ser_stb, exp_stb);
            end
            if (m_if.ser_d !== exp_d) begin
                n_fail++;
                $display("FAIL %s ser_d cycle %0d: got %b want %b", name, c, m_if.ser_d, exp_d);
            end
            if (m_if.ser_frame !== in_frame) begin
                n_fail++;
                $display("FAIL %s frame cycle %0d: got %b want %b", name, c, m_if.ser_frame, in_frame);
            end
            if (m_if.tx_ready !== !in_frame) begin
                n_fail++;
                $display("FAIL %s ready cycle %0d: got %b want %b", name, c, m_if.tx_ready, !in_frame);
            end
            if (scramble && in_frame) m_if.tx_data = 8'($urandom);
        end
        n_checks += 2;
        if (cap_n !== W) begin
            n_fail++;
            $display("FAIL %s latch strobe count: got %0d want %0d", name, cap_n, W);
        end
        if (cap !== word) begin
            n_fail++;
            $display("FAIL %s latch word: got %h want %h", name, cap, word);
        end
    endtask

    task automatic test_reset;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (m_if.tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset ready cycle %0d: got %b want 1", c, m_if.tx_ready);
            end
            if (m_if.ser_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL reset stb cycle %0d: got %b want 0", c, m_if.ser_stb);
            end
            if (m_if.ser_frame !== 1'b0) begin
                n_fail++;
                $display("FAIL reset frame cycle %0d: got %b want 0", c, m_if.ser_frame);
            end
            if (m_if.ser_d !== 1'b0) begin
                n_fail++;
                $display("FAIL reset ser_d cycle %0d: got %b want 0", c, m_if.ser_d);
            end
        end
    endtask

    task automatic test_word_a5;
        start_word(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, "a5");
    endtask

    task automatic test_back_to_back;
        start_word(8'h3C, 1'b1);
        check_frame(8'h3C, 1'b1, "b2b_first");
        // Now in cycle 41 with tx_valid still high: edge 41 takes the next word.
        m_if.tx_data = 8'hC3;
        check_frame(8'hC3, 1'b0, "b2b_second");
        m_if.tx_valid = 1'b0;
    endtask

    task automatic test_reset_mid_word;
        start_word(8'hFF, 1'b0);
        // Bit 3 HIGH phase covers cycles 18-19.
        repeat (18) @(negedge clk);
        n_checks++;
        if (m_if.ser_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset pre stb: got %b want 1", m_if.ser_stb);
        end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (m_if.ser_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset stb: got %b want 0", m_if.ser_stb);
        end
        if (m_if.ser_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset frame: got %b want 0", m_if.ser_frame);
        end
        if (m_if.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset ready: got %b want 1", m_if.tx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_word(8'h81, 1'b0);
        check_frame(8'h81, 1'b0, "after_reset");
    endtask

    task automatic test_small_config;
        logic [6:0] exp_stb;
        logic [6:0] exp_d;
        logic [6:0] exp_frame;
        // Index c-1 for cycles 1..7.
        exp_stb   = 7'b0010010;
        exp_d     = 7'b0000111;
        exp_frame = 7'b0111111;
        @(negedge clk);
        s_if.tx_data  = 2'b10;
        s_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        s_if.tx_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (s_if.ser_stb !== exp_stb[c-1]) begin
                n_fail++;
                $display("FAIL small stb cycle %0d: got %b want %b", c, s_if.ser_stb, exp_stb[c-1]);
            end
            if (s_if.ser_d !== exp_d[c-1]) begin
                n_fail++;
                $display("FAIL small ser_d cycle %0d: got %b want %b", c, s_if.ser_d, exp_d[c-1]);
            end
            if (s_if.ser_frame !== exp_frame[c-1]) begin
                n_fail++;
                $display("FAIL small frame cycle %0d: got %b want %b", c, s_if.ser_frame, exp_frame[c-1]);
            end
            if (s_if.tx_ready !== !exp_frame[c-1]) begin
                n_fail++;
                $display("FAIL small ready cycle %0d: got %b want %b", c, s_if.tx_ready, !exp_frame[c-1]);
            end
        end
    endtask

    task automatic test_valid_through_reset;
        @(negedge clk);
        rst_n         = 1'b0;
        m_if.tx_data  = 8'h5A;
        m_if.tx_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_if.ser_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL vrst frame in reset: got %b want 0", m_if.ser_frame);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_if.tx_valid = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (m_if.ser_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL vrst frame: got %b want 1", m_if.ser_frame);
        end
        if (m_if.tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL vrst ready: got %b want 0", m_if.tx_ready);
        end
        if (m_if.ser_d !== 1'b0) begin
            n_fail++;
            $display("FAIL vrst ser_d: got %b want 0", m_if.ser_d);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cap           = '0;
        cap_n         = 0;
        rst_n         = 1'b0;
        m_if.tx_data  = '0;
        m_if.tx_valid = 1'b0;
        s_if.tx_data  = '0;
        s_if.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_word_a5();
        test_back_to_back();
        test_reset_mid_word();
        test_small_config();
        test_valid_through_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
